// File: rtl/ad2hsst_pkg.sv
// Shared constants, state encoding and checksum helper for the AD -> HSST transmit framer.
package ad2hsst_pkg;

  localparam logic [31:0] IDLE_WORD = 32'h5050_50BC;
  localparam logic [7:0]  K_SOF     = 8'hFB;
  localparam logic [7:0]  K_EOF     = 8'hFD;
  localparam logic [7:0]  K_IDLE    = 8'hBC;
  localparam logic [7:0]  SOF_TAG   = 8'h50;
  localparam logic [3:0]  K_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    PAY  = 2'd2,
    EOF  = 2'd3
  } state_t;

  // Sum of the four bytes of a word, zero-extended, modulo 2^16.
  function automatic logic [15:0] byte_sum(input logic [31:0] w);
    return 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
  endfunction

endpackage

// File: rtl/ad2hsst_word_fifo.sv
// Single-clock first-word-fall-through FIFO of 32-bit words with full/empty/count.
module ad2hsst_word_fifo #(
  parameter int DEPTH_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [31:0]            wr_data,
  input  logic                   pop,
  output logic [31:0]            rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_WIDTH:0]   count
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [31:0]            mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q;
  logic [DEPTH_WIDTH:0]   count_q;
  logic                   do_pop;
  logic                   do_push;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ad2hsst_framer.sv
// Packs AD samples into words, buffers them and emits SOF/payload/EOF frames with idle fill on the HSST lane.
module ad2hsst_framer
  import ad2hsst_pkg::*;
#(
  parameter int SAMPLE_W    = 8,
  parameter int DEPTH_WIDTH = 8,
  parameter int FRAME_LEN   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] ad_data,
  input  logic                ad_vld,
  input  logic                tx_rdy,
  output logic [31:0]         tx_data,
  output logic [3:0]          tx_kchar,
  output logic                ad_ovf,
  output logic [15:0]         frame_cnt
);

  localparam int PAY_WORDS = FRAME_LEN / 4;
  localparam logic [DEPTH_WIDTH:0] FRAME_WORDS = (DEPTH_WIDTH + 1)'(PAY_WORDS);
  localparam logic [15:0] LAST_BEAT = 16'(PAY_WORDS - 1);

  // Packer: bytes 0..2 are held until byte 3 arrives and completes the word.
  logic [1:0]  idx_q;
  logic [23:0] lo_q;
  logic        push;
  logic [31:0] push_word;

  assign push      = ad_vld && (idx_q == 2'd3);
  assign push_word = {ad_data, lo_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      lo_q  <= '0;
    end else if (ad_vld) begin
      case (idx_q)
        2'd0:    lo_q[7:0]   <= ad_data;
        2'd1:    lo_q[15:8]  <= ad_data;
        2'd2:    lo_q[23:16] <= ad_data;
        default: lo_q        <= lo_q;
      endcase
      idx_q <= idx_q + 1'b1;
    end
  end

  logic                 pop;
  logic [31:0]          fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DEPTH_WIDTH:0] fifo_count;

  ad2hsst_word_fifo #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_word),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)                           ad_ovf <= 1'b0;
    else if (push && fifo_full && !pop)   ad_ovf <= 1'b1;
  end

  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [31:0] tx_data_d;
  logic [3:0]  tx_kchar_d;

  // tx_rdy low freezes every piece of framer state and substitutes the idle word.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    csum_d     = csum_q;
    seq_d      = seq_q;
    fcnt_d     = fcnt_q;
    tx_data_d  = IDLE_WORD;
    tx_kchar_d = K_BYTE0;
    pop        = 1'b0;
    if (tx_rdy) begin
      case (state_q)
        IDLE: if (fifo_count >= FRAME_WORDS) state_d = SOF;
        SOF: begin
          tx_data_d = {seq_q, SOF_TAG, K_SOF};
          csum_d    = '0;
          beat_d    = '0;
          state_d   = PAY;
        end
        PAY: begin
          tx_data_d  = fifo_head;
          tx_kchar_d = 4'b0000;
          pop        = !fifo_empty;
          csum_d     = csum_q + byte_sum(fifo_head);
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = EOF;
        end
        EOF: begin
          tx_data_d = {csum_q, 8'h00, K_EOF};
          seq_d     = seq_q + 1'b1;
          fcnt_d    = fcnt_q + 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      csum_q   <= '0;
      seq_q    <= '0;
      fcnt_q   <= '0;
      tx_data  <= IDLE_WORD;
      tx_kchar <= K_BYTE0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      csum_q   <= csum_d;
      seq_q    <= seq_d;
      fcnt_q   <= fcnt_d;
      tx_data  <= tx_data_d;
      tx_kchar <= tx_kchar_d;
    end
  end

  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_ad2hsst_framer.sv
// Scenario bench for ad2hsst_framer: frame-level reference model, lane monitor with expected queue.
module tb_ad2hsst_framer;

  localparam logic [31:0] IDLE_W     = 32'h5050_50BC;
  localparam int          FIFO_WORDS = 256;
  localparam int          PAY_WORDS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ad_data = '0;
  logic        ad_vld = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [31:0] tx_data;
  logic [3:0]  tx_kchar;
  logic        ad_ovf;
  logic [15:0] frame_cnt;

  ad2hsst_framer #(.SAMPLE_W(8), .DEPTH_WIDTH(8), .FRAME_LEN(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ad_data   (ad_data),
    .ad_vld    (ad_vld),
    .tx_rdy    (tx_rdy),
    .tx_data   (tx_data),
    .tx_kchar  (tx_kchar),
    .ad_ovf    (ad_ovf),
    .frame_cnt (frame_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [3:0]  expk_q[$];
  logic [7:0]  pend_q[$];
  logic [31:0] grp_q[$];
  int          model_cnt = 0;
  logic [15:0] m_seq = '0;
  int          frames_built = 0;
  logic        exp_ovf = 1'b0;

  function automatic void model_reset();
    exp_q.delete();
    expk_q.delete();
    pend_q.delete();
    grp_q.delete();
    model_cnt    = 0;
    m_seq        = '0;
    frames_built = 0;
    exp_ovf      = 1'b0;
  endfunction

  function automatic void build_frame();
    logic [15:0] sum;
    logic [31:0] w;
    sum = '0;
    exp_q.push_back({m_seq, 8'h50, 8'hFB});
    expk_q.push_back(4'b0001);
    for (int i = 0; i < PAY_WORDS; i++) begin
      w = grp_q.pop_front();
      sum = sum + 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
      exp_q.push_back(w);
      expk_q.push_back(4'b0000);
    end
    exp_q.push_back({sum, 8'h00, 8'hFD});
    expk_q.push_back(4'b0001);
    m_seq = m_seq + 16'd1;
    frames_built++;
  endfunction

  function automatic void model_sample(input logic [7:0] d);
    logic [31:0] w;
    pend_q.push_back(d);
    if (pend_q.size() == 4) begin
      w = {pend_q[3], pend_q[2], pend_q[1], pend_q[0]};
      pend_q.delete();
      if (model_cnt >= FIFO_WORDS) begin
        exp_ovf = 1'b1;
      end else begin
        model_cnt++;
        grp_q.push_back(w);
        if (grp_q.size() == PAY_WORDS) build_frame();
      end
    end
  endfunction

  // ---------------- lane monitor / scoreboard ----------------
  bit mon_en = 1'b0;
  int idle_run = 0;
  int gap_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_kchar === 4'b0001 && tx_data === IDLE_W) begin
        idle_run++;
      end else begin
        logic [31:0] e;
        logic [3:0]  ek;
        gap_q.push_back(idle_run);
        idle_run = 0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mon_unexpected: got %h/%b, wanted idle %h/0001", tx_data, tx_kchar, IDLE_W);
        end else begin
          e  = exp_q.pop_front();
          ek = expk_q.pop_front();
          if ({tx_data, tx_kchar} !== {e, ek}) begin
            bad++;
            $display("FAIL mon_word: got %h/%b, wanted %h/%b", tx_data, tx_kchar, e, ek);
          end
        end
        if (tx_kchar === 4'b0000) model_cnt--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [7:0] d);
    ad_data = d;
    ad_vld  = 1'b1;
    model_sample(d);
    @(posedge clk); #1;
    ad_vld  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    tx_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      idle_cycle();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d words still expected, wanted 0", name, exp_q.size());
    end
    repeat (4) idle_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    tx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (tx_data !== IDLE_W) begin
        bad++; $display("FAIL reset_data: got %h wanted %h", tx_data, IDLE_W);
      end
      total++;
      if (tx_kchar !== 4'b0001) begin
        bad++; $display("FAIL reset_kchar: got %b wanted 0001", tx_kchar);
      end
      total++;
      if (frame_cnt !== 16'd0) begin
        bad++; $display("FAIL reset_frame_cnt: got %0d wanted 0", frame_cnt);
      end
      total++;
      if (ad_ovf !== 1'b0) begin
        bad++; $display("FAIL reset_ovf: got %b wanted 0", ad_ovf);
      end
    end
    idle_run = 0;
    mon_en   = 1'b1;
  endtask

  task automatic test_basic_frame(input logic [7:0] base, input string name);
    tx_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send_sample(base + 8'(i));
    drain(name);
    total++;
    if (frame_cnt !== 16'(frames_built)) begin
      bad++; $display("FAIL %s_frame_cnt: got %0d wanted %0d", name, frame_cnt, frames_built);
    end
    @(negedge clk);
    total++;
    if (tx_data !== IDLE_W || tx_kchar !== 4'b0001) begin
      bad++; $display("FAIL %s_back_to_idle: got %h/%b wanted %h/0001", name, tx_data, tx_kchar, IDLE_W);
    end
    #1;
  endtask

  task automatic test_back_to_back();
    tx_rdy = 1'b0;
    for (int i = 0; i < 32; i++) send_sample(8'($urandom_range(0, 255)));
    idle_cycle();
    gap_q.delete();
    tx_rdy = 1'b1;
    drain("b2b");
    total++;
    if (gap_q.size() < 12) begin
      bad++; $display("FAIL b2b_words: got %0d lane words wanted 12", gap_q.size());
    end else begin
      total++;
      if (gap_q[6] != 1) begin
        bad++; $display("FAIL b2b_gap: got %0d idle words between frames wanted 1", gap_q[6]);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    tx_rdy = 1'b1;
    gap_q.delete();
    for (int i = 0; i < 16; i++) send_sample(8'(i));
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      idle_cycle();
      if (tx_kchar === 4'b0000) n++;
    end
    tx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 tx_rdy = 1'b1;
    drain("stall");
    total++;
    if (gap_q.size() < 6) begin
      bad++; $display("FAIL stall_words: got %0d lane words wanted 6", gap_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        total++;
        if (gap_q[i] != ((i == 3) ? 3 : 0)) begin
          bad++; $display("FAIL stall_gap%0d: got %0d idles wanted %0d", i, gap_q[i], (i == 3) ? 3 : 0);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tx_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) send_sample(8'($urandom_range(0, 255)));
      else idle_cycle();
    end
    drain("random");
    total++;
    if (frame_cnt !== 16'(frames_built)) begin
      bad++; $display("FAIL random_frame_cnt: got %0d wanted %0d", frame_cnt, frames_built);
    end
    total++;
    if (ad_ovf !== exp_ovf) begin
      bad++; $display("FAIL random_ovf: got %b wanted %b", ad_ovf, exp_ovf);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    tx_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send_sample(8'($urandom_range(0, 255)));
    n = 0;
    for (int i = 0; i < 40 && n < 1; i++) begin
      idle_cycle();
      if (tx_kchar === 4'b0000) n++;
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (tx_data !== IDLE_W || tx_kchar !== 4'b0001) begin
      bad++; $display("FAIL midrst_idle: got %h/%b wanted %h/0001", tx_data, tx_kchar, IDLE_W);
    end
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++; $display("FAIL midrst_frame_cnt: got %0d wanted 0", frame_cnt);
    end
    idle_run = 0;
    mon_en   = 1'b1;
    #1;
    repeat (10) idle_cycle();
    test_basic_frame(8'h00, "midrst");
  endtask

  task automatic test_overflow();
    tx_rdy = 1'b0;
    for (int i = 0; i < (FIFO_WORDS + 1) * 4; i++) begin
      send_sample(8'($urandom_range(0, 255)));
      if (i == (FIFO_WORDS + 1) * 4 - 2) begin
        total++;
        if (ad_ovf !== 1'b0) begin
          bad++; $display("FAIL ovf_early: got %b wanted 0", ad_ovf);
        end
      end
    end
    total++;
    if (ad_ovf !== exp_ovf) begin
      bad++; $display("FAIL ovf_rise: got %b wanted %b", ad_ovf, exp_ovf);
    end
    drain("ovf");
    total++;
    if (ad_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got %b wanted 1", ad_ovf);
    end
    total++;
    if (frame_cnt !== 16'(frames_built)) begin
      bad++; $display("FAIL ovf_frame_cnt: got %0d wanted %0d", frame_cnt, frames_built);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_frame(8'h00, "frame0");
    test_basic_frame(8'h10, "frame1");
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
